// File: rtl/test_verilog_pkg.sv
// Shared definitions for the test_verilog counter family (up-counter and down timer).
package test_verilog_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/test_verilog_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is high on the last enabled cycle of each group.
module test_verilog_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  // With PRESCALE=1 the counter never leaves 0, so tick reduces to a constant 1.
  assign tick = (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/test_verilog_down_timer.sv
// Loadable down-counting timer with one-cycle underflow pulse and optional auto-reload.
module test_verilog_down_timer
  import test_verilog_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             underflow_q, underflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;
  logic             run_en;
  logic             step;
  logic             zero_step;

  assign run_en    = (state_q == RUN) && enable;
  assign step      = run_en && tick;
  assign zero_step = step && (count_q == '0);

  test_verilog_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .clr (load),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // load overrides everything, including a coincident zero step
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = RUN;
    end else if (zero_step && !reload_en) begin
      state_d = DONE;
    end
  end

  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_comb begin
    count_d     = count_q;
    reload_d    = reload_q;
    underflow_d = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
    end else if (step) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        underflow_d = 1'b1;
        if (reload_en) begin
          count_d = reload_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      reload_q    <= '0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign count     = count_q;
  assign underflow = underflow_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_test_verilog_down_timer.sv
// Bench for the down timer: vector table with a scoreboard queue, plus reset, prescale and period sequences.
module tb_test_verilog_down_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       load;
  logic [7:0] load_value;
  logic       reload_en;

  logic [7:0] count1, count4;
  logic       underflow1, underflow4;
  logic       busy1, busy4;
  logic       done1, done4;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] lv;
    logic       re;
    logic [7:0] c;
    logic       uf;
    logic       bz;
    logic       dn;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] c;
    logic       uf;
    logic       bz;
    logic       dn;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  test_verilog_down_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .load_value(load_value),
    .reload_en (reload_en),
    .count     (count1),
    .underflow (underflow1),
    .busy      (busy1),
    .done      (done1)
  );

  test_verilog_down_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .load_value(load_value),
    .reload_en (reload_en),
    .count     (count4),
    .underflow (underflow4),
    .busy      (busy4),
    .done      (done4)
  );

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic ld, input logic [7:0] lv, input logic re,
                     input logic [7:0] c, input logic uf, input logic bz, input logic dn);
    vec_t v;
    v.en = en; v.ld = ld; v.lv = lv; v.re = re;
    v.c = c; v.uf = uf; v.bz = bz; v.dn = dn;
    vecs.push_back(v);
  endtask

  // Called at a negedge: drive, queue expectation, sample at the following negedge.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    enable     = v.en;
    load       = v.ld;
    load_value = v.lv;
    reload_en  = v.re;
    e.idx = idx; e.c = v.c; e.uf = v.uf; e.bz = v.bz; e.dn = v.dn;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = exp_q.pop_front();
    chk($sformatf("vec%0d count", got.idx), count1, got.c);
    chk($sformatf("vec%0d underflow", got.idx), underflow1, got.uf);
    chk($sformatf("vec%0d busy", got.idx), busy1, got.bz);
    chk($sformatf("vec%0d done", got.idx), done1, got.dn);
    $display("vec%0d en=%0d ld=%0d lv=%0d re=%0d -> count=%0d uf=%0d busy=%0d done=%0d",
             got.idx, v.en, v.ld, v.lv, v.re, count1, underflow1, busy1, done1);
  endtask

  task automatic do_reset();
    enable = 1'b0; load = 1'b0; load_value = 8'd0; reload_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cnt;
    bit e;
    bit seen;

    // Vector table, applied from IDLE after reset
    add(1,1,8'd3,0, 8'd3,0,1,0);   // one-shot load 3
    add(1,0,8'd0,0, 8'd2,0,1,0);
    add(1,0,8'd0,0, 8'd1,0,1,0);
    add(1,0,8'd0,0, 8'd0,0,1,0);
    add(1,0,8'd0,0, 8'd0,1,0,1);   // zero step -> DONE with pulse
    add(1,0,8'd0,0, 8'd0,0,0,1);
    add(0,0,8'd0,0, 8'd0,0,0,1);
    add(1,1,8'd2,1, 8'd2,0,1,0);   // auto-reload load 2 from DONE
    add(1,0,8'd0,1, 8'd1,0,1,0);
    add(1,0,8'd0,1, 8'd0,0,1,0);
    add(1,0,8'd0,1, 8'd2,1,1,0);
    add(1,0,8'd0,1, 8'd1,0,1,0);
    add(1,0,8'd0,1, 8'd0,0,1,0);
    add(1,0,8'd0,1, 8'd2,1,1,0);
    add(0,0,8'd0,1, 8'd2,0,1,0);   // enable gap holds
    add(1,0,8'd0,1, 8'd1,0,1,0);
    add(1,0,8'd0,1, 8'd0,0,1,0);
    add(1,1,8'd7,1, 8'd7,0,1,0);   // load beats zero step
    add(1,0,8'd0,1, 8'd6,0,1,0);
    add(1,1,8'd0,0, 8'd0,0,1,0);   // load 0
    add(1,0,8'd0,0, 8'd0,1,0,1);
    add(1,1,8'd1,0, 8'd1,0,1,0);
    add(1,0,8'd0,1, 8'd0,0,1,0);   // reload_en only matters at zero step
    add(1,0,8'd0,0, 8'd0,1,0,1);

    // Power-on reset, checked before any clock edge
    enable = 1'b0; load = 1'b0; load_value = 8'd0; reload_en = 1'b0;
    rst = 1'b1;
    #2;
    chk("por count", count1, 0);
    chk("por busy", busy1, 0);
    chk("por done", done1, 0);
    chk("por underflow", underflow1, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // Async reset mid-run with count=5, no clock edge in between
    do_reset();
    enable = 1'b1; load = 1'b1; load_value = 8'd5; reload_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; enable = 1'b0;
    chk("arst pre count", count1, 5);
    #1 rst = 1'b1;
    #1;
    chk("arst count", count1, 0);
    chk("arst busy", busy1, 0);
    chk("arst done", done1, 0);
    chk("arst underflow", underflow1, 0);
    chk("arst count4", count4, 0);
    $display("async reset: count=%0d busy=%0d done=%0d uf=%0d", count1, busy1, done1, underflow1);
    @(negedge clk);
    rst = 1'b0;

    // Prescale 4, load 1 auto-reload, random enable gaps: period 8 enabled cycles
    do_reset();
    enable = 1'b1; load = 1'b1; load_value = 8'd1; reload_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    chk("presc load count", count4, 1);
    n = 0;
    for (int k = 0; k < 48; k++) begin
      e = ($urandom_range(0, 3) != 0);
      enable = e;
      @(posedge clk);
      @(negedge clk);
      if (e) n++;
      chk($sformatf("presc%0d count", k), count4, ((n % 8) < 4) ? 1 : 0);
      chk($sformatf("presc%0d underflow", k), underflow4, (e && n > 0 && (n % 8) == 0) ? 1 : 0);
      $display("presc%0d en=%0d n=%0d -> count=%0d uf=%0d", k, e, n, count4, underflow4);
    end

    // Load 8'hFF with reload: two consecutive 256-cycle periods
    do_reset();
    enable = 1'b1; load = 1'b1; load_value = 8'hFF; reload_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      seen = 0;
      while (!seen && cnt < 600) begin
        @(posedge clk);
        @(negedge clk);
        cnt++;
        seen = underflow1;
      end
      chk($sformatf("period%0d length", p), seen ? cnt : -1, 256);
      chk($sformatf("period%0d reload count", p), count1, 8'hFF);
      $display("period%0d: %0d cycles, count=%0d", p, cnt, count1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
